// File: rtl/des_key_sched_ctrl_if.sv
// Key-in / subkey-out bundle between the DES key-schedule sequencer, its key source and the Feistel consumer.
interface des_key_sched_ctrl_if;
    logic        start;
    logic        decrypt;
    logic [1:64] key;
    logic        sk_ready;
    logic        sk_valid;
    logic [1:48] subkey;
    logic [3:0]  sk_round;
    logic        busy;
    logic        done;
    logic        parity_err;

    modport master (
        output start, decrypt, key, sk_ready,
        input  sk_valid, subkey, sk_round, busy, done, parity_err
    );

    modport slave (
        input  start, decrypt, key, sk_ready,
        output sk_valid, subkey, sk_round, busy, done, parity_err
    );
endinterface

// File: rtl/des_key_sched_ctrl.sv
// DES key-schedule sequencer: one 56-bit C||D register rotated per round, one PC-2 on its output.
// Optional key byte odd-parity rejection is enabled by defining DES_KEY_PARITY_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start; key/decrypt sampled here
// RUN   | subkey cnt_q presented; advances on each sk_valid && sk_ready
// DONE  | one-cycle done pulse after the 16th transfer
module des_key_sched_ctrl (
    input  logic                 clk,
    input  logic                 rst_n,
    des_key_sched_ctrl_if.slave  sk_if
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:56] cd_q, cd_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dir_q, dir_d;
    logic        perr_d;
    logic        sk_valid_q, busy_q, done_q, parity_err_q;

    logic [1:64] k;
    logic [1:56] key_pc1;
    logic        key_bad;
    logic        single_shift;

    function automatic logic [1:56] rot_left(input logic [1:56] v, input logic two);
        logic [1:28] c;
        logic [1:28] d;
        c = v[1:28];
        d = v[29:56];
        if (two)
            return {c[3:28], c[1:2], d[3:28], d[1:2]};
        else
            return {c[2:28], c[1], d[2:28], d[1]};
    endfunction

    function automatic logic [1:56] rot_right(input logic [1:56] v, input logic two);
        logic [1:28] c;
        logic [1:28] d;
        c = v[1:28];
        d = v[29:56];
        if (two)
            return {c[27:28], c[1:26], d[27:28], d[1:26]};
        else
            return {c[28], c[1:27], d[28], d[1:27]};
    endfunction

    assign k = sk_if.key;

    assign key_pc1 = {
        k[57], k[49], k[41], k[33], k[25], k[17], k[9],
        k[1],  k[58], k[50], k[42], k[34], k[26], k[18],
        k[10], k[2],  k[59], k[51], k[43], k[35], k[27],
        k[19], k[11], k[3],  k[60], k[52], k[44], k[36],
        k[63], k[55], k[47], k[39], k[31], k[23], k[15],
        k[7],  k[62], k[54], k[46], k[38], k[30], k[22],
        k[14], k[6],  k[61], k[53], k[45], k[37], k[29],
        k[21], k[13], k[5],  k[28], k[20], k[12], k[4]
    };

`ifdef DES_KEY_PARITY_CHECK_EN
    assign key_bad = ~(^k[1:8])   | ~(^k[9:16])  | ~(^k[17:24]) | ~(^k[25:32]) |
                     ~(^k[33:40]) | ~(^k[41:48]) | ~(^k[49:56]) | ~(^k[57:64]);
`else
    logic parity_bits_unused;
    assign parity_bits_unused = ^{k[8], k[16], k[24], k[32], k[40], k[48], k[56], k[64]};
    assign key_bad = 1'b0;
`endif

    // shift[cnt+2] (encrypt) and shift[16-cnt] (decrypt) are both 1 exactly at cnt 0, 7, 14
    assign single_shift = (cnt_q == 4'd0) || (cnt_q == 4'd7) || (cnt_q == 4'd14);

    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        perr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sk_if.start) begin
                    if (key_bad) begin
                        perr_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        // decrypt starts at C16D16, which equals C0D0
                        cd_d    = sk_if.decrypt ? key_pc1 : rot_left(key_pc1, 1'b0);
                        dir_d   = sk_if.decrypt;
                        cnt_d   = 4'd0;
                    end
                end
            end
            ST_RUN: begin
                if (sk_valid_q && sk_if.sk_ready) begin
                    if (cnt_q == 4'd15) begin
                        state_d = ST_DONE;
                        cnt_d   = 4'd0;
                    end else begin
                        cd_d  = dir_q ? rot_right(cd_q, ~single_shift)
                                      : rot_left(cd_q, ~single_shift);
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cd_q         <= '0;
            cnt_q        <= 4'd0;
            dir_q        <= 1'b0;
            sk_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cd_q         <= cd_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            sk_valid_q   <= (state_d == ST_RUN);
            busy_q       <= (state_d != ST_IDLE);
            done_q       <= (state_d == ST_DONE);
            parity_err_q <= perr_d;
        end
    end

    assign sk_if.subkey = {
        cd_q[14], cd_q[17], cd_q[11], cd_q[24], cd_q[1],  cd_q[5],
        cd_q[3],  cd_q[28], cd_q[15], cd_q[6],  cd_q[21], cd_q[10],
        cd_q[23], cd_q[19], cd_q[12], cd_q[4],  cd_q[26], cd_q[8],
        cd_q[16], cd_q[7],  cd_q[27], cd_q[20], cd_q[13], cd_q[2],
        cd_q[41], cd_q[52], cd_q[31], cd_q[37], cd_q[47], cd_q[55],
        cd_q[30], cd_q[40], cd_q[51], cd_q[45], cd_q[33], cd_q[48],
        cd_q[44], cd_q[49], cd_q[39], cd_q[56], cd_q[34], cd_q[53],
        cd_q[46], cd_q[42], cd_q[50], cd_q[36], cd_q[29], cd_q[32]
    };

    assign sk_if.sk_valid   = sk_valid_q;
    assign sk_if.sk_round   = cnt_q;
    assign sk_if.busy       = busy_q;
    assign sk_if.done       = done_q;
    assign sk_if.parity_err = parity_err_q;

endmodule

// File: tb/tb_des_key_sched_ctrl.sv
// Scoreboard bench for des_key_sched_ctrl against the published K1..K16 of key 133457799BBCDFF1.
module tb_des_key_sched_ctrl;

    localparam logic [63:0] KEY_A     = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_A_EVN = 64'h133457799BBCDFF0;
    localparam logic [63:0] KEY_B     = 64'h0E329232EA6D0D73;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    des_key_sched_ctrl_if sk_if();

    des_key_sched_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sk_if (sk_if)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [51:0] exp_q[$];
    logic [47:0] k_enc [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic push_sched(input logic dec);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] r;
            r = 4'(i);
            exp_q.push_back({r, dec ? k_enc[15-i] : k_enc[i]});
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 64'(sk_if.sk_valid), 64'd0);
        check_eq({tag, "_busy"},  64'(sk_if.busy), 64'd0);
        check_eq({tag, "_done"},  64'(sk_if.done), 64'd0);
        check_eq({tag, "_perr"},  64'(sk_if.parity_err), 64'd0);
        check_eq({tag, "_round"}, 64'(sk_if.sk_round), 64'd0);
        check_eq({tag, "_subkey"}, 64'(sk_if.subkey), 64'd0);
    endtask

    // drive start for one edge while IDLE; expected subkeys are queued as the stimulus goes out
    task automatic start_sched(input logic [63:0] k, input logic dec, output int s_cyc);
        sk_if.key     = k;
        sk_if.decrypt = dec;
        sk_if.start   = 1'b1;
        push_sched(dec);
        @(posedge clk);
        #1;
        sk_if.start = 1'b0;
        s_cyc = cyc;
        check_eq("start_busy",  64'(sk_if.busy), 64'd1);
        check_eq("start_valid", 64'(sk_if.sk_valid), 64'd1);
        check_eq("start_round", 64'(sk_if.sk_round), 64'd0);
    endtask

    task automatic wait_round(input logic [3:0] r);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (sk_if.sk_valid && sk_if.sk_round == r) found = 1'b1;
        end
        check_eq("wait_round_seen", 64'(found), 64'd1);
    endtask

    task automatic wait_done(input int s_cyc, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            if (sk_if.done) seen = 1'b1;
        end
        check_eq("done_seen", 64'(seen), 64'd1);
        if (seen) begin
            lat = cyc - s_cyc;
            check_eq("done_valid_low", 64'(sk_if.sk_valid), 64'd0);
            check_eq("done_busy", 64'(sk_if.busy), 64'd1);
            @(negedge clk);
            check_eq("done_one_cycle", 64'(sk_if.done), 64'd0);
            check_eq("idle_busy", 64'(sk_if.busy), 64'd0);
        end
    endtask

    // scoreboard pop on every transfer; a stalled subkey must be unchanged next cycle
    initial begin
        bit          hold_v;
        logic [47:0] hold_sk;
        logic [3:0]  hold_rd;
        logic [51:0] e;
        hold_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    check_eq("stall_valid",  64'(sk_if.sk_valid), 64'd1);
                    check_eq("stall_subkey", 64'(sk_if.subkey), 64'(hold_sk));
                    check_eq("stall_round",  64'(sk_if.sk_round), 64'(hold_rd));
                end
                hold_v = 1'b0;
                if (sk_if.sk_valid) begin
                    if (sk_if.sk_ready) begin
                        if (exp_q.size() == 0) begin
                            check_eq("sb_unexpected_subkey", 64'(sk_if.subkey), 64'hDEAD);
                        end else begin
                            e = exp_q.pop_front();
                            check_eq("sb_subkey", 64'(sk_if.subkey), 64'(e[47:0]));
                            check_eq("sb_round",  64'(sk_if.sk_round), 64'(e[51:48]));
                        end
                    end else begin
                        hold_v  = 1'b1;
                        hold_sk = sk_if.subkey;
                        hold_rd = sk_if.sk_round;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s2, lat;
        sk_if.start    = 1'b0;
        sk_if.decrypt  = 1'b0;
        sk_if.key      = '0;
        sk_if.sk_ready = 1'b0;

        #12;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sk_if.sk_ready = 1'b1;

        // encrypt, no backpressure
        start_sched(KEY_A, 1'b0, s1);
        wait_done(s1, lat);
        check_eq("enc_done_latency", 64'(lat), 64'd16);

        // decrypt: reversed order
        start_sched(KEY_A, 1'b1, s1);
        wait_done(s1, lat);
        check_eq("dec_done_latency", 64'(lat), 64'd16);

        // three-cycle stall at round 4
        start_sched(KEY_A, 1'b0, s1);
        wait_round(4'd4);
        sk_if.sk_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sk_if.sk_ready = 1'b1;
        wait_done(s1, lat);
        check_eq("stall_done_latency", 64'(lat), 64'd19);

        // start with another key mid-run must be ignored
        start_sched(KEY_A, 1'b0, s1);
        wait_round(4'd7);
        sk_if.key     = KEY_B;
        sk_if.decrypt = 1'b1;
        sk_if.start   = 1'b1;
        @(posedge clk);
        #1;
        sk_if.start = 1'b0;
        check_eq("ignored_start_round", 64'(sk_if.sk_round), 64'd8);
        wait_done(s1, lat);
        check_eq("ignored_done_latency", 64'(lat), 64'd16);

        // start held through DONE: accepted only on cycle 18
        start_sched(KEY_A, 1'b1, s1);
        wait_round(4'd15);
        sk_if.key     = KEY_A;
        sk_if.decrypt = 1'b0;
        sk_if.start   = 1'b1;
        push_sched(1'b0);
        @(posedge clk);
        #1;
        check_eq("b2b_done_cycle17", 64'(sk_if.done), 64'd1);
        @(posedge clk);
        #1;
        check_eq("b2b_idle_cycle18", 64'(sk_if.busy), 64'd0);
        @(posedge clk);
        #1;
        sk_if.start = 1'b0;
        s2 = cyc;
        check_eq("b2b_accept_busy", 64'(sk_if.busy), 64'd1);
        check_eq("b2b_period", 64'(s2 - s1), 64'd18);
        wait_done(s2, lat);
        check_eq("b2b_done_latency", 64'(lat), 64'd16);

        // async reset at round 9, then a clean decrypt schedule
        start_sched(KEY_A, 1'b0, s1);
        wait_round(4'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        exp_q.delete();
        @(posedge clk);
        #1;
        check_all_zero("abort_held");
        rst_n = 1'b1;
        start_sched(KEY_A, 1'b1, s1);
        wait_done(s1, lat);
        check_eq("post_reset_latency", 64'(lat), 64'd16);

`ifdef DES_KEY_PARITY_CHECK_EN
        sk_if.key     = KEY_A_EVN;
        sk_if.decrypt = 1'b0;
        sk_if.start   = 1'b1;
        @(posedge clk);
        #1;
        sk_if.start = 1'b0;
        check_eq("perr_pulse", 64'(sk_if.parity_err), 64'd1);
        check_eq("perr_busy",  64'(sk_if.busy), 64'd0);
        check_eq("perr_valid", 64'(sk_if.sk_valid), 64'd0);
        @(posedge clk);
        #1;
        check_eq("perr_one_cycle", 64'(sk_if.parity_err), 64'd0);
        check_eq("perr_still_idle", 64'(sk_if.busy), 64'd0);
        start_sched(KEY_A, 1'b0, s1);
        wait_done(s1, lat);
        check_eq("perr_recover_latency", 64'(lat), 64'd16);
`else
        // parity bits are dropped by PC-1, so an even-parity byte gives the same schedule
        start_sched(KEY_A_EVN, 1'b0, s1);
        check_eq("noperr_flag", 64'(sk_if.parity_err), 64'd0);
        wait_done(s1, lat);
        check_eq("noperr_latency", 64'(lat), 64'd16);
`endif

        repeat (2) @(negedge clk);
        check_eq("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
